timer_apb_arb: RTL and testbench
================================

TIMER_APB_ARB -- requirements
Module: timer_apb_arb

Interface
REQ-001 The block SHALL have the parameter TIMEOUT, default 16, which is the maximum number of ACCESS cycles before a transfer is aborted; legal range is 2..255.
REQ-002 Port sys_clk SHALL be an input, 1 bit wide: the single clock, with all logic on the rising edge.
REQ-003 Port sys_rst SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-004 For each requester k in {0,1} (0 = CPU, 1 = DMA), the following SHALL be inputs:
- rqk_req, 1 bit: transfer request, held until done.
- rqk_write, 1 bit: write when high, read when low.
- rqk_addr, 12 bits: register address.
- rqk_wdata, 32 bits: write data.
- rqk_strb, 4 bits: byte strobes.
REQ-005 For each requester k, the following SHALL be outputs:
- rqk_done, 1 bit: one-cycle completion pulse.
- rqk_err, 1 bit: error qualifier, valid with done.
- rqk_rdata, 32 bits: read data, valid with done.
REQ-006 The timer-side APB master ports SHALL be:
- Outputs: tim_psel 1, tim_penable 1, tim_pwrite 1, tim_paddr 12, tim_pwdata 32, tim_pstrb 4.
- Inputs: tim_pready 1, tim_pslverr 1, tim_prdata 32.
REQ-007 The block SHALL have the output busy, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-008 The FSM SHALL have the states IDLE, SETUP, ACCESS and RESP.
REQ-009 IDLE SHALL behave as follows:
- If any rqk_req is high, latch the winner's write/addr/wdata/strb and go to SETUP.
- Otherwise stay in IDLE.
REQ-010 Arbitration SHALL be round-robin:
- With a single requester, that requester wins.
- With both requesting, the requester not granted last wins.
- The last-granted pointer resets to 1, so requester 0 wins the first tie.
REQ-011 SETUP SHALL drive tim_psel=1 and tim_penable=0 with the latched command on paddr/pwrite/pwdata/pstrb, then go unconditionally to ACCESS.
REQ-012 ACCESS SHALL drive tim_psel=1 and tim_penable=1 with the command held stable.
- tim_pready=1: capture tim_prdata (reads only; writes return 0) and tim_pslverr, then go to RESP.
REQ-013 An ACCESS cycle counter SHALL be cleared on entry to ACCESS.
- If TIMEOUT ACCESS cycles elapse with pready low, go to RESP with err=1 and rdata=0.
- The APB transfer is dropped (psel low from the next cycle).
REQ-014 RESP SHALL pulse the granted requester's rqk_done for exactly one cycle, with rdata and err valid; the other requester's done stays 0.
- RESP then goes to IDLE and the last-granted pointer is updated.
REQ-015 Requesters SHALL drop req (or present a new command) on the edge ending their done cycle.
- IDLE samples req combinationally.
- A req held high across IDLE is a new request.
REQ-016 Latency SHALL be as follows:
- With zero wait states, done is asserted 3 cycles after req is first sampled in IDLE (IDLE->SETUP->ACCESS->RESP).
- Each APB wait state adds 1 cycle.
REQ-017 A requester whose req drops mid-transfer SHALL NOT abort the transfer: it completes and done still pulses.
REQ-018 tim_psel and tim_penable SHALL be 0 in IDLE and RESP; all APB outputs SHALL be registered.
REQ-019 rqk_rdata and rqk_err SHALL hold their last value outside done cycles; only done qualifies them.

Reset
REQ-020 While sys_rst=1 on a rising edge, the following SHALL apply:
- The FSM goes to IDLE.
- All outputs are 0.
- The pointer is 1 and the timeout counter is 0.
REQ-021 A reset during SETUP or ACCESS SHALL abandon the transfer with no done pulse, and psel SHALL be low the cycle after the reset edge.

Structure
REQ-022 Package timer_pkg SHALL hold:
- the FSM state encoding;
- the requester ID constants (RQ_CPU=0, RQ_DMA=1);
- the default TIMEOUT;
- the APB address and data widths.
REQ-023 The round-robin grant logic SHALL be the single sub-module timer_rr_pick (inputs: req[1:0] and the last pointer; outputs: grant id and valid); everything else is flat.

Verification
REQ-024 Reset/single write: rq0 writes addr 0x004 with data 0x0000_0003 and strb 0xF; pready=1 immediately -> one SETUP and one ACCESS cycle on APB, rq0_done 3 cycles later, err=0.
REQ-025 Read with waits: rq1 reads 0x008; pready is held low for 2 ACCESS cycles and the slave returns 0xDEAD_BEEF -> rq1_rdata=0xDEAD_BEEF with done at cycle 5, psel high for 4 cycles.
REQ-026 Tie and fairness: rq0 and rq1 request together and keep re-requesting -> grants alternate 0,1,0,1 with no back-to-back repeat.
REQ-027 Timeout: with TIMEOUT=4 and pready stuck low -> exactly 4 ACCESS cycles, then done with err=1 and rdata=0, and psel low afterwards.
REQ-028 Slave error: pslverr=1 with pready -> err=1 on done for that requester only.
REQ-029 Reset mid-ACCESS: sys_rst is pulsed during wait states -> no done pulse, busy=0 and psel=0 the next cycle, and a fresh rq0 request is then served normally.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer APB arbiter: FSM encoding, requester IDs,
// bus widths and the default access timeout.
package timer_pkg;

    localparam int APB_AW          = 12;
    localparam int APB_DW          = 32;
    localparam int APB_SW          = APB_DW / 8;
    localparam int TIMEOUT_DEFAULT = 16;
    localparam int NUM_RQ          = 2;

    localparam logic RQ_CPU = 1'b0;
    localparam logic RQ_DMA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } arb_state_t;

endpackage

// File: rtl/timer_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one
// not granted last time.
module timer_rr_pick
    import timer_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        grant = RQ_CPU;
        if (req == 2'b11) begin
            grant = ~last;
        end else if (req[RQ_DMA]) begin
            grant = RQ_DMA;
        end
    end

endmodule

// File: rtl/timer_apb_arb.sv
// Arbitrates a CPU and a DMA requester onto one APB master port toward the
// timer block, with a bounded ACCESS phase and per-requester responses.
module timer_apb_arb
    import timer_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
)
(
    input  logic              sys_clk,
    input  logic              sys_rst,

    input  logic              rq0_req,
    input  logic              rq0_write,
    input  logic [APB_AW-1:0] rq0_addr,
    input  logic [APB_DW-1:0] rq0_wdata,
    input  logic [APB_SW-1:0] rq0_strb,
    output logic              rq0_done,
    output logic              rq0_err,
    output logic [APB_DW-1:0] rq0_rdata,

    input  logic              rq1_req,
    input  logic              rq1_write,
    input  logic [APB_AW-1:0] rq1_addr,
    input  logic [APB_DW-1:0] rq1_wdata,
    input  logic [APB_SW-1:0] rq1_strb,
    output logic              rq1_done,
    output logic              rq1_err,
    output logic [APB_DW-1:0] rq1_rdata,

    output logic              tim_psel,
    output logic              tim_penable,
    output logic              tim_pwrite,
    output logic [APB_AW-1:0] tim_paddr,
    output logic [APB_DW-1:0] tim_pwdata,
    output logic [APB_SW-1:0] tim_pstrb,
    input  logic              tim_pready,
    input  logic              tim_pslverr,
    input  logic [APB_DW-1:0] tim_prdata,

    output logic              busy
);

    localparam int CNT_W = 8;

    arb_state_t        state_reg, state_next;
    logic              last_reg, last_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              gnt_reg;
    logic              cmd_write_reg;
    logic [APB_AW-1:0] cmd_addr_reg;
    logic [APB_DW-1:0] cmd_wdata_reg;
    logic [APB_SW-1:0] cmd_strb_reg;
    logic              psel_reg, penable_reg;

    logic              latch_cmd;
    logic              finish;
    logic              finish_err;
    logic [APB_DW-1:0] finish_data;

    logic              pick_id;
    logic              pick_valid;

    logic [1:0]        req_vec;
    logic              write_arr [NUM_RQ];
    logic [APB_AW-1:0] addr_arr  [NUM_RQ];
    logic [APB_DW-1:0] wdata_arr [NUM_RQ];
    logic [APB_SW-1:0] strb_arr  [NUM_RQ];

    assign req_vec      = {rq1_req, rq0_req};
    assign write_arr[0] = rq0_write;
    assign write_arr[1] = rq1_write;
    assign addr_arr[0]  = rq0_addr;
    assign addr_arr[1]  = rq1_addr;
    assign wdata_arr[0] = rq0_wdata;
    assign wdata_arr[1] = rq1_wdata;
    assign strb_arr[0]  = rq0_strb;
    assign strb_arr[1]  = rq1_strb;

    timer_rr_pick u_pick (
        .req   (req_vec),
        .last  (last_reg),
        .grant (pick_id),
        .valid (pick_valid)
    );

    always_comb begin
        state_next  = state_reg;
        last_next   = last_reg;
        cnt_next    = cnt_reg;
        latch_cmd   = 1'b0;
        finish      = 1'b0;
        finish_err  = 1'b0;
        finish_data = '0;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    latch_cmd  = 1'b1;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_next   = '0;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A ready slave on the final allowed cycle still completes normally.
                if (tim_pready) begin
                    finish      = 1'b1;
                    finish_err  = tim_pslverr;
                    finish_data = cmd_write_reg ? '0 : tim_prdata;
                    state_next  = ST_RESP;
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    finish      = 1'b1;
                    finish_err  = 1'b1;
                    state_next  = ST_RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_RESP: begin
                last_next  = gnt_reg;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg     <= ST_IDLE;
            last_reg      <= 1'b1;
            cnt_reg       <= '0;
            gnt_reg       <= 1'b0;
            cmd_write_reg <= 1'b0;
            cmd_addr_reg  <= '0;
            cmd_wdata_reg <= '0;
            cmd_strb_reg  <= '0;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            last_reg    <= last_next;
            cnt_reg     <= cnt_next;
            psel_reg    <= (state_next == ST_SETUP) || (state_next == ST_ACCESS);
            penable_reg <= (state_next == ST_ACCESS);
            if (latch_cmd) begin
                gnt_reg       <= pick_id;
                cmd_write_reg <= write_arr[pick_id];
                cmd_addr_reg  <= addr_arr[pick_id];
                cmd_wdata_reg <= wdata_arr[pick_id];
                cmd_strb_reg  <= strb_arr[pick_id];
            end
        end
    end

    // Response registers per requester; rdata/err hold until that requester's next done.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RQ; gi++) begin : g_rq
            localparam logic ID = 1'(gi);
            logic              done_reg;
            logic              err_reg;
            logic [APB_DW-1:0] rdata_reg;

            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    done_reg  <= 1'b0;
                    err_reg   <= 1'b0;
                    rdata_reg <= '0;
                end else begin
                    done_reg <= finish && (gnt_reg == ID);
                    if (finish && (gnt_reg == ID)) begin
                        err_reg   <= finish_err;
                        rdata_reg <= finish_data;
                    end
                end
            end
        end
    endgenerate

    assign rq0_done    = g_rq[0].done_reg;
    assign rq0_err     = g_rq[0].err_reg;
    assign rq0_rdata   = g_rq[0].rdata_reg;
    assign rq1_done    = g_rq[1].done_reg;
    assign rq1_err     = g_rq[1].err_reg;
    assign rq1_rdata   = g_rq[1].rdata_reg;

    assign tim_psel    = psel_reg;
    assign tim_penable = penable_reg;
    assign tim_pwrite  = cmd_write_reg;
    assign tim_paddr   = cmd_addr_reg;
    assign tim_pwdata  = cmd_wdata_reg;
    assign tim_pstrb   = cmd_strb_reg;
    assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_timer_apb_arb.sv
// Directed bench for timer_apb_arb: a wait-state-programmable APB slave,
// an APB activity monitor and a linear list of checked transactions.
module tb_timer_apb_arb;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;

    logic        rq0_req = 1'b0, rq0_write = 1'b0;
    logic [11:0] rq0_addr = '0;
    logic [31:0] rq0_wdata = '0;
    logic [3:0]  rq0_strb = '0;
    logic        rq0_done, rq0_err;
    logic [31:0] rq0_rdata;

    logic        rq1_req = 1'b0, rq1_write = 1'b0;
    logic [11:0] rq1_addr = '0;
    logic [31:0] rq1_wdata = '0;
    logic [3:0]  rq1_strb = '0;
    logic        rq1_done, rq1_err;
    logic [31:0] rq1_rdata;

    logic        tim_psel, tim_penable, tim_pwrite;
    logic [11:0] tim_paddr;
    logic [31:0] tim_pwdata;
    logic [3:0]  tim_pstrb;
    logic        tim_pready, tim_pslverr;
    logic [31:0] tim_prdata;
    logic        busy;

    int          slv_waits = 0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err = 1'b0;
    int          wait_seen = 0;

    int psel_cycles = 0, setup_cycles = 0, acc_cycles = 0;
    int done0_cnt = 0, done1_cnt = 0, both_done_cnt = 0;
    logic        cap_write;
    logic [11:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_strb;

    int n_total = 0, n_pass = 0, n_fail = 0;
    int grant_q[$];

    always #5 sys_clk = ~sys_clk;

    timer_apb_arb #(.TIMEOUT(4)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .rq0_req     (rq0_req),
        .rq0_write   (rq0_write),
        .rq0_addr    (rq0_addr),
        .rq0_wdata   (rq0_wdata),
        .rq0_strb    (rq0_strb),
        .rq0_done    (rq0_done),
        .rq0_err     (rq0_err),
        .rq0_rdata   (rq0_rdata),
        .rq1_req     (rq1_req),
        .rq1_write   (rq1_write),
        .rq1_addr    (rq1_addr),
        .rq1_wdata   (rq1_wdata),
        .rq1_strb    (rq1_strb),
        .rq1_done    (rq1_done),
        .rq1_err     (rq1_err),
        .rq1_rdata   (rq1_rdata),
        .tim_psel    (tim_psel),
        .tim_penable (tim_penable),
        .tim_pwrite  (tim_pwrite),
        .tim_paddr   (tim_paddr),
        .tim_pwdata  (tim_pwdata),
        .tim_pstrb   (tim_pstrb),
        .tim_pready  (tim_pready),
        .tim_pslverr (tim_pslverr),
        .tim_prdata  (tim_prdata),
        .busy        (busy)
    );

    // Slave: holds pready low for slv_waits ACCESS cycles, then completes.
    assign tim_pready  = tim_psel && tim_penable && (wait_seen >= slv_waits);
    assign tim_pslverr = slv_err;
    assign tim_prdata  = slv_rdata;

    always @(posedge sys_clk) begin
        if (tim_psel && tim_penable && !tim_pready) wait_seen <= wait_seen + 1;
        else if (!tim_psel) wait_seen <= 0;
    end

    always @(negedge sys_clk) begin
        psel_cycles  += int'(tim_psel);
        setup_cycles += int'(tim_psel && !tim_penable);
        acc_cycles   += int'(tim_psel && tim_penable);
        done0_cnt    += int'(rq0_done);
        done1_cnt    += int'(rq1_done);
        both_done_cnt += int'(rq0_done && rq1_done);
        if (tim_psel && tim_penable && tim_pready) begin
            cap_write = tim_pwrite;
            cap_addr  = tim_paddr;
            cap_wdata = tim_pwdata;
            cap_strb  = tim_pstrb;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, return cycles from first IDLE sample to done (-1 if none).
    task automatic run_txn(input int k, input logic wr, input logic [11:0] a,
                           input logic [31:0] wd, input logic [3:0] st,
                           output int lat, output logic [31:0] rd, output logic er);
        @(posedge sys_clk); #1;
        if (k == 0) begin
            rq0_write = wr; rq0_addr = a; rq0_wdata = wd; rq0_strb = st; rq0_req = 1'b1;
        end else begin
            rq1_write = wr; rq1_addr = a; rq1_wdata = wd; rq1_strb = st; rq1_req = 1'b1;
        end
        lat = -1;
        rd  = '0;
        er  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge sys_clk);
            if ((k == 0) ? rq0_done : rq1_done) begin
                lat = c;
                rd  = (k == 0) ? rq0_rdata : rq1_rdata;
                er  = (k == 0) ? rq0_err : rq1_err;
                break;
            end
        end
        #1;
        rq0_req = 1'b0;
        rq1_req = 1'b0;
        $display("txn rq%0d %s addr=0x%03h lat=%0d rdata=0x%08h err=%0b",
                 k, wr ? "WR" : "RD", a, lat, rd, er);
    endtask

    // Both requesters keep requesting until n done pulses are collected.
    task automatic run_tie(input int n);
        @(posedge sys_clk); #1;
        rq0_write = 1'b0; rq0_addr = 12'h010; rq0_req = 1'b1;
        rq1_write = 1'b0; rq1_addr = 12'h014; rq1_req = 1'b1;
        grant_q.delete();
        for (int c = 0; c < n * 6 + 10 && grant_q.size() < n; c++) begin
            @(negedge sys_clk);
            if (rq0_done && rq1_done) grant_q.push_back(9);
            else if (rq0_done)        grant_q.push_back(0);
            else if (rq1_done)        grant_q.push_back(1);
        end
        #1;
        rq0_req = 1'b0;
        rq1_req = 1'b0;
        $display("tie %0d grants collected: %p", grant_q.size(), grant_q);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          p0, s0, a0, d0, d1;

        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_psel", tim_psel, 0);
        chk("rst_penable", tim_penable, 0);
        chk("rst_done0", rq0_done, 0);
        chk("rst_done1", rq1_done, 0);
        chk("rst_rdata1", rq1_rdata, 0);
        chk("rst_paddr", tim_paddr, 0);
        sys_rst = 1'b0;
        $display("reset released");

        // Single zero-wait write from rq0
        p0 = psel_cycles; s0 = setup_cycles; a0 = acc_cycles; d0 = done0_cnt; d1 = done1_cnt;
        slv_waits = 0; slv_rdata = 32'h1234_5678; slv_err = 1'b0;
        run_txn(0, 1'b1, 12'h004, 32'h0000_0003, 4'hF, lat, rd, er);
        chk("wr_lat", lat, 3);
        chk("wr_err", er, 0);
        chk("wr_rdata_zero", rd, 0);
        chk("wr_setup_cycles", setup_cycles - s0, 1);
        chk("wr_access_cycles", acc_cycles - a0, 1);
        chk("wr_psel_cycles", psel_cycles - p0, 2);
        chk("wr_paddr", cap_addr, 32'h004);
        chk("wr_pwdata", cap_wdata, 32'h0000_0003);
        chk("wr_pwrite", cap_write, 1);
        chk("wr_pstrb", cap_strb, 4'hF);
        chk("wr_done0_pulses", done0_cnt - d0, 1);
        chk("wr_done1_quiet", done1_cnt - d1, 0);

        // Read from rq1 with two wait states
        p0 = psel_cycles; d0 = done0_cnt;
        slv_waits = 2; slv_rdata = 32'hDEAD_BEEF;
        run_txn(1, 1'b0, 12'h008, 32'h0, 4'h0, lat, rd, er);
        chk("rd_lat", lat, 5);
        chk("rd_rdata", rd, 32'hDEAD_BEEF);
        chk("rd_err", er, 0);
        chk("rd_psel_cycles", psel_cycles - p0, 4);
        chk("rd_paddr", cap_addr, 32'h008);
        chk("rd_pwrite", cap_write, 0);
        chk("rd_done0_quiet", done0_cnt - d0, 0);
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rd_hold_rdata1", rq1_rdata, 32'hDEAD_BEEF);
        chk("rd_hold_rdata0", rq0_rdata, 0);
        chk("idle_busy", busy, 0);

        // Tie with continuous re-requests: strict alternation starting at rq0
        slv_waits = 0; slv_rdata = 32'h1111_1111;
        d0 = both_done_cnt;
        run_tie(4);
        chk("tie_count", grant_q.size(), 4);
        chk("tie_g0", grant_q[0], 0);
        chk("tie_g1", grant_q[1], 1);
        chk("tie_g2", grant_q[2], 0);
        chk("tie_g3", grant_q[3], 1);
        chk("tie_no_dual_done", both_done_cnt - d0, 0);

        // Slave error reported only to the granted requester
        d0 = done0_cnt;
        slv_err = 1'b1;
        run_txn(1, 1'b1, 12'h00C, 32'hA5A5_A5A5, 4'h3, lat, rd, er);
        chk("slverr_err1", er, 1);
        chk("slverr_err0_clear", rq0_err, 0);
        chk("slverr_done0_quiet", done0_cnt - d0, 0);
        slv_err = 1'b0;
        run_txn(0, 1'b0, 12'h000, 32'h0, 4'h0, lat, rd, er);
        chk("after_slverr_err0", er, 0);
        chk("after_slverr_hold_err1", rq1_err, 1);

        // Timeout: pready never rises, exactly 4 ACCESS cycles
        p0 = psel_cycles; a0 = acc_cycles;
        slv_waits = 255; slv_rdata = 32'hCAFE_F00D;
        run_txn(0, 1'b0, 12'h020, 32'h0, 4'h0, lat, rd, er);
        chk("to_lat", lat, 6);
        chk("to_err", er, 1);
        chk("to_rdata", rd, 0);
        chk("to_access_cycles", acc_cycles - a0, 4);
        chk("to_psel_cycles", psel_cycles - p0, 5);
        p0 = psel_cycles;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("to_psel_low_after", psel_cycles - p0, 0);

        // Ready on the last allowed ACCESS cycle completes without error
        a0 = acc_cycles;
        slv_waits = 3;
        run_txn(0, 1'b0, 12'h024, 32'h0, 4'h0, lat, rd, er);
        chk("edge_lat", lat, 6);
        chk("edge_err", er, 0);
        chk("edge_rdata", rd, 32'hCAFE_F00D);
        chk("edge_access_cycles", acc_cycles - a0, 4);

        // Reset pulse during ACCESS wait states
        slv_waits = 255;
        @(posedge sys_clk); #1;
        rq0_write = 1'b0; rq0_addr = 12'h030; rq0_req = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("mid_in_access", tim_penable, 1);
        d0 = done0_cnt; d1 = done1_cnt;
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        rq0_req = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_psel", tim_psel, 0);
        chk("mid_rst_rdata0", rq0_rdata, 0);
        chk("mid_rst_err1", rq1_err, 0);
        repeat (4) @(posedge sys_clk);
        #1;
        chk("mid_rst_no_done", (done0_cnt - d0) + (done1_cnt - d1), 0);
        $display("reset pulsed mid-access");

        // Pointer back at 1 after reset: rq0 wins the first tie
        slv_waits = 0; slv_rdata = 32'h2222_2222;
        run_tie(2);
        chk("post_rst_tie_count", grant_q.size(), 2);
        chk("post_rst_tie_g0", grant_q[0], 0);
        chk("post_rst_tie_g1", grant_q[1], 1);

        slv_rdata = 32'h0BAD_F00D;
        run_txn(0, 1'b0, 12'h040, 32'h0, 4'h0, lat, rd, er);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_rdata", rd, 32'h0BAD_F00D);
        chk("post_rst_err", er, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
